// File: rtl/multicycle_main_fsm.sv
// Main sequencing FSM of the multicycle control unit: fetch, decode, execute, memory, writeback.
// Latency: outputs are combinational from the current state (FETCH also uses mem_ready); NOP 2, branch 3, ALU/store 4, load 5 cycles.
// Backpressure: FETCH, MEMRD and MEMWR hold their state and outputs until mem_ready; mem_ready outside a request is ignored.
module multicycle_main_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         instr_class,
    input  logic               imm,
    input  logic               load,
    input  logic               set_flags,
    input  logic               cmp,
    input  logic               rd_is_pc,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ALUOp,
    output logic [1:0]         ResultSrc,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic [1:0]         FlagW,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    // Instruction classes as presented by the instruction register.
    localparam logic [1:0] CLS_DP   = 2'b00;
    localparam logic [1:0] CLS_MEM  = 2'b01;
    localparam logic [1:0] CLS_BR   = 2'b10;

    // Datapath select encodings.
    localparam logic [1:0] SRCA_REG  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_MEMADR = STATE_W'(2),
        S_MEMRD  = STATE_W'(3),
        S_MEMWB  = STATE_W'(4),
        S_MEMWR  = STATE_W'(5),
        S_EXECR  = STATE_W'(6),
        S_EXECI  = STATE_W'(7),
        S_ALUWB  = STATE_W'(8),
        S_BRANCH = STATE_W'(9)
    } state_t;

    state_t r_state;
    state_t w_next;

    // Ungated decode of the current state; the reset gate is applied at the ports.
    logic       w_mem_req;
    logic       w_irwrite;
    logic       w_nextpc;
    logic       w_adrsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic       w_aluop;
    logic [1:0] w_resultsrc;
    logic       w_pcs;
    logic       w_regw;
    logic       w_memw;
    logic [1:0] w_flagw;
    logic       w_instr_done;
    logic       w_flag_upd;

    // Both S-bit ops and compares update all four flags.
    assign w_flag_upd = set_flags | cmp;

    // Next-state selection; unused encodings fall back to FETCH.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (instr_class)
                    CLS_MEM: w_next = S_MEMADR;
                    CLS_DP:  w_next = imm ? S_EXECI : S_EXECR;
                    CLS_BR:  w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = load ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Control decode per state; anything not set in a state stays 0.
    always_comb begin
        w_mem_req    = 1'b0;
        w_irwrite    = 1'b0;
        w_nextpc     = 1'b0;
        w_adrsrc     = 1'b0;
        w_alusrca    = SRCA_REG;
        w_alusrcb    = SRCB_REG;
        w_aluop      = 1'b0;
        w_resultsrc  = RES_ALUOUT;
        w_pcs        = 1'b0;
        w_regw       = 1'b0;
        w_memw       = 1'b0;
        w_flagw      = 2'b00;
        w_instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                // Fetch from PC while the ALU computes PC+4; IR and PC load only on the ready cycle.
                w_mem_req   = 1'b1;
                w_adrsrc    = 1'b0;
                w_alusrca   = SRCA_PC;
                w_alusrcb   = SRCB_FOUR;
                w_resultsrc = RES_ALU;
                w_irwrite   = mem_ready;
                w_nextpc    = mem_ready;
            end
            S_DECODE: begin
                w_alusrca    = SRCA_PC;
                w_alusrcb    = SRCB_FOUR;
                w_resultsrc  = RES_ALU;
                // A NOP retires straight out of decode.
                w_instr_done = (instr_class == 2'b11);
            end
            S_MEMADR: begin
                w_alusrca = SRCA_REG;
                w_alusrcb = SRCB_IMM;
                w_aluop   = 1'b0;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_adrsrc  = 1'b1;
            end
            S_MEMWB: begin
                w_resultsrc  = RES_RDATA;
                w_regw       = 1'b1;
                w_pcs        = rd_is_pc;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                // Write enable is held through the whole wait so the memory sees a stable request.
                w_mem_req    = 1'b1;
                w_adrsrc     = 1'b1;
                w_memw       = 1'b1;
                w_instr_done = mem_ready;
            end
            S_EXECR: begin
                w_alusrca = SRCA_REG;
                w_alusrcb = SRCB_REG;
                w_aluop   = 1'b1;
                w_flagw   = {w_flag_upd, w_flag_upd};
            end
            S_EXECI: begin
                w_alusrca = SRCA_REG;
                w_alusrcb = SRCB_IMM;
                w_aluop   = 1'b1;
                w_flagw   = {w_flag_upd, w_flag_upd};
            end
            S_ALUWB: begin
                // Compares only set flags: no register or PC write.
                w_resultsrc  = RES_ALUOUT;
                w_regw       = ~cmp;
                w_pcs        = rd_is_pc & ~cmp;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca    = SRCA_REG;
                w_alusrcb    = SRCB_IMM;
                w_aluop      = 1'b0;
                w_resultsrc  = RES_ALU;
                w_pcs        = 1'b1;
                w_instr_done = 1'b1;
            end
            default: begin
                w_mem_req = 1'b0;
            end
        endcase
    end

    // State register: synchronous active-low reset returns to FETCH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // While reset is low every output is 0, so an abandoned instruction never writes.
    assign mem_req    = rst & w_mem_req;
    assign IRWrite    = rst & w_irwrite;
    assign NextPC     = rst & w_nextpc;
    assign AdrSrc     = rst & w_adrsrc;
    assign ALUSrcA    = rst ? w_alusrca   : 2'b00;
    assign ALUSrcB    = rst ? w_alusrcb   : 2'b00;
    assign ALUOp      = rst & w_aluop;
    assign ResultSrc  = rst ? w_resultsrc : 2'b00;
    assign PCS        = rst & w_pcs;
    assign RegW       = rst & w_regw;
    assign MemW       = rst & w_memw;
    assign FlagW      = rst ? w_flagw     : 2'b00;
    assign instr_done = rst & w_instr_done;
    assign state      = rst ? r_state     : '0;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: directed per-cycle vectors, expectations queued, monitor compares on negedge.
// Each stimulus step pushes one expected output word for the cycle it drives.
// Monitor pops one expectation per falling edge while the queue holds entries.
module tb_multicycle_main_fsm;

    logic       clk;
    logic       rst;
    logic [1:0] instr_class;
    logic       imm, load, set_flags, cmp, rd_is_pc, mem_ready;
    logic       mem_req, IRWrite, NextPC, AdrSrc, ALUOp, PCS, RegW, MemW, instr_done;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, FlagW;
    logic [3:0] state;

    multicycle_main_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .instr_class(instr_class), .imm(imm), .load(load),
        .set_flags(set_flags), .cmp(cmp), .rd_is_pc(rd_is_pc), .mem_ready(mem_ready),
        .mem_req(mem_req), .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW), .instr_done(instr_done),
        .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       req, irw, npc, adr;
        logic [1:0] asa, asb;
        logic       aop;
        logic [1:0] rs;
        logic       pcs, rw, mw;
        logic [1:0] fw;
        logic       done;
    } exp_t;

    // Hand-written expected output words per situation.
    localparam exp_t E_RST     = '0;
    localparam exp_t E_F_WAIT  = '{st:4'd0, req:1'b1, asa:2'b01, asb:2'b10, rs:2'b10, default:'0};
    localparam exp_t E_F_RDY   = '{st:4'd0, req:1'b1, irw:1'b1, npc:1'b1, asa:2'b01, asb:2'b10, rs:2'b10, default:'0};
    localparam exp_t E_DEC     = '{st:4'd1, asa:2'b01, asb:2'b10, rs:2'b10, default:'0};
    localparam exp_t E_DEC_NOP = '{st:4'd1, asa:2'b01, asb:2'b10, rs:2'b10, done:1'b1, default:'0};
    localparam exp_t E_MADR    = '{st:4'd2, asb:2'b01, default:'0};
    localparam exp_t E_MRD     = '{st:4'd3, req:1'b1, adr:1'b1, default:'0};
    localparam exp_t E_MWB     = '{st:4'd4, rs:2'b01, rw:1'b1, done:1'b1, default:'0};
    localparam exp_t E_MWB_PC  = '{st:4'd4, rs:2'b01, rw:1'b1, pcs:1'b1, done:1'b1, default:'0};
    localparam exp_t E_MWR     = '{st:4'd5, req:1'b1, adr:1'b1, mw:1'b1, default:'0};
    localparam exp_t E_MWR_END = '{st:4'd5, req:1'b1, adr:1'b1, mw:1'b1, done:1'b1, default:'0};
    localparam exp_t E_EXR_F   = '{st:4'd6, aop:1'b1, fw:2'b11, default:'0};
    localparam exp_t E_EXI_NF  = '{st:4'd7, asb:2'b01, aop:1'b1, default:'0};
    localparam exp_t E_AWB     = '{st:4'd8, rw:1'b1, done:1'b1, default:'0};
    localparam exp_t E_AWB_CMP = '{st:4'd8, done:1'b1, default:'0};
    localparam exp_t E_AWB_PC  = '{st:4'd8, rw:1'b1, pcs:1'b1, done:1'b1, default:'0};
    localparam exp_t E_BR      = '{st:4'd9, asb:2'b01, rs:2'b10, pcs:1'b1, done:1'b1, default:'0};

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    errors;

    exp_t  m_exp;
    exp_t  m_got;
    string m_nm;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare the DUT output word against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_nm  = name_q.pop_front();
            m_got = {state, mem_req, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp,
                     ResultSrc, PCS, RegW, MemW, FlagW, instr_done};
            checks++;
            if (m_got !== m_exp) begin
                errors++;
                $display("FAIL %s got %h required %h (t=%0t)", m_nm, m_got, m_exp, $time);
            end
        end
    end

    task automatic set_instr(input logic [1:0] c, input logic i, input logic l,
                             input logic s, input logic cm, input logic pc);
        instr_class = c; imm = i; load = l; set_flags = s; cmp = cm; rd_is_pc = pc;
    endtask

    // Drive one cycle: queue its expectation, then advance to just after the next edge.
    task automatic step(input string nm, input logic rdy, input exp_t e);
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        mem_ready = 1'b0;
        set_instr(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Power-up reset for two cycles.
        step("reset0", 1'b0, E_RST);
        step("reset1", 1'b0, E_RST);
        rst = 1'b1;

        // Register ALU op with S bit.
        set_instr(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("dp_fetch", 1'b1, E_F_RDY);
        step("dp_decode", 1'b1, E_DEC);
        step("dp_execr", 1'b1, E_EXR_F);
        step("dp_aluwb", 1'b1, E_AWB);

        // Compare to PC: flags only, no register or PC write.
        set_instr(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("cmp_fetch", 1'b1, E_F_RDY);
        step("cmp_decode", 1'b1, E_DEC);
        step("cmp_execr", 1'b1, E_EXR_F);
        step("cmp_aluwb", 1'b1, E_AWB_CMP);

        // Immediate op writing PC, no flags.
        set_instr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("dpi_fetch", 1'b1, E_F_RDY);
        step("dpi_decode", 1'b1, E_DEC);
        step("dpi_execi", 1'b1, E_EXI_NF);
        step("dpi_aluwb", 1'b1, E_AWB_PC);

        // Load with three wait cycles in MEMRD: 8 cycles total.
        set_instr(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ld_fetch", 1'b1, E_F_RDY);
        step("ld_decode", 1'b1, E_DEC);
        step("ld_memadr", 1'b1, E_MADR);
        step("ld_memrd_w0", 1'b0, E_MRD);
        step("ld_memrd_w1", 1'b0, E_MRD);
        step("ld_memrd_w2", 1'b0, E_MRD);
        step("ld_memrd_rdy", 1'b1, E_MRD);
        step("ld_memwb", 1'b0, E_MWB);

        // Store with two fetch waits and ready arriving on the third MEMWR cycle.
        set_instr(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("st_fetch_w0", 1'b0, E_F_WAIT);
        step("st_fetch_w1", 1'b0, E_F_WAIT);
        step("st_fetch_rdy", 1'b1, E_F_RDY);
        step("st_decode", 1'b0, E_DEC);
        step("st_memadr", 1'b0, E_MADR);
        step("st_memwr_w0", 1'b0, E_MWR);
        step("st_memwr_w1", 1'b0, E_MWR);
        step("st_memwr_rdy", 1'b1, E_MWR_END);

        // Branch.
        set_instr(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("br_fetch", 1'b1, E_F_RDY);
        step("br_decode", 1'b1, E_DEC);
        step("br_branch", 1'b1, E_BR);

        // NOP retires in decode.
        set_instr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("nop_fetch", 1'b1, E_F_RDY);
        step("nop_decode", 1'b1, E_DEC_NOP);

        // Load into PC.
        set_instr(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("ldpc_fetch", 1'b1, E_F_RDY);
        step("ldpc_decode", 1'b1, E_DEC);
        step("ldpc_memadr", 1'b1, E_MADR);
        step("ldpc_memrd", 1'b1, E_MRD);
        step("ldpc_memwb", 1'b1, E_MWB_PC);

        // Reset while a store waits in MEMWR: no write request in the reset cycles.
        set_instr(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("abort_fetch", 1'b1, E_F_RDY);
        step("abort_decode", 1'b1, E_DEC);
        step("abort_memadr", 1'b0, E_MADR);
        step("abort_memwr", 1'b0, E_MWR);
        rst = 1'b0;
        step("abort_reset0", 1'b0, E_RST);
        step("abort_reset1", 1'b0, E_RST);
        rst = 1'b1;
        step("abort_refetch", 1'b0, E_F_WAIT);
        set_instr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("post_fetch", 1'b1, E_F_RDY);
        step("post_decode", 1'b1, E_DEC_NOP);

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog against a stalled simulation.
    initial begin
        #50000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
